// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one DRAM request port between instruction and data ports.
// Optional watchdog on downstream transactions is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int unsigned RELEASE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        reset,
    input  logic        clock,
    input  logic [71:0] imem_in,
    output logic [33:0] imem_out,
    input  logic [71:0] dmem_in,
    output logic [33:0] dmem_out,
    output logic [71:0] dram_in,
    input  logic [33:0] dram_out
);

    // Request layout: {valid, instr, mode[1:0], addr[31:0], wdata[31:0], wstrb[3:0]}
    // Response layout: {rdata[31:0], ready, error}
    localparam int unsigned ValidBit = 71;
    localparam int unsigned ReadyBit = 1;

    if (RELEASE_CYCLES < 1 || RELEASE_CYCLES > 15) begin : g_bad_release
        $error("RELEASE_CYCLES must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 16) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 16");
    end

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StRelease} state_e;

    state_e      state_q, state_d;
    logic [71:0] req_q, req_d;
    logic        last_d_q, last_d_d;   // 1 when the data port held the last grant
    logic [3:0]  rel_cnt_q, rel_cnt_d;
    logic [33:0] resp;
    logic        done;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned WdW = ($clog2(TIMEOUT_CYCLES) > 12) ? $clog2(TIMEOUT_CYCLES) : 12;
    logic [WdW-1:0] wdog_q, wdog_d;
    logic           expired;
    assign expired = (wdog_q == WdW'(TIMEOUT_CYCLES - 1));
`endif

    assign dram_in = req_q;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        last_d_d  = last_d_q;
        rel_cnt_d = rel_cnt_q;
        resp      = '0;
        done      = 1'b0;
        imem_out  = '0;
        dmem_out  = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        wdog_d    = wdog_q;
`endif
        case (state_q)
            StIdle: begin
                if (dmem_in[ValidBit] && (!imem_in[ValidBit] || !last_d_q)) begin
                    req_d    = dmem_in;
                    last_d_d = 1'b1;
                    state_d  = StBusyD;
                end else if (imem_in[ValidBit]) begin
                    req_d    = imem_in;
                    last_d_d = 1'b0;
                    state_d  = StBusyI;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                wdog_d = '0;
`endif
            end
            StBusyI, StBusyD: begin
                if (dram_out[ReadyBit]) begin
                    resp = dram_out;
                    done = 1'b1;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (expired) begin
                    resp = {32'h0, 1'b1, 1'b1};
                    done = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
                // The IDLE cycle that follows RELEASE is the last low cycle of the gap.
                if (done) begin
                    req_d = '0;
                    if (RELEASE_CYCLES > 1) begin
                        state_d   = StRelease;
                        rel_cnt_d = 4'(RELEASE_CYCLES - 1);
                    end else begin
                        state_d = StIdle;
                    end
                end
                if (state_q == StBusyI) begin
                    imem_out = resp;
                end else begin
                    dmem_out = resp;
                end
            end
            StRelease: begin
                rel_cnt_d = rel_cnt_q - 1'b1;
                if (rel_cnt_q <= 4'd1) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            req_q     <= '0;
            last_d_q  <= 1'b0;
            rel_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            last_d_q  <= last_d_d;
            rel_cnt_q <= rel_cnt_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

endmodule
